// File: rtl/bin_to_sseg_scan_pkg.sv
// rtl/bin_to_sseg_scan_pkg.sv - shared constants, converter state enum and BCD helper
package bin_to_sseg_scan_pkg;

  localparam logic [3:0] BCD_ERR      = 4'hE;
  localparam int         N_DIGITS_DEF = 4;
  localparam int         W_BIN_DEF    = 14;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} conv_state_e;

  // Double-dabble correction applied to a nibble before each shift.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/bin_to_sseg_scan_bin2bcd_seq.sv
// rtl/bin_to_sseg_scan_bin2bcd_seq.sv - sequential shift-and-add-3 binary to BCD converter
module bin2bcd_seq
  import bin_to_sseg_scan_pkg::*;
#(
  parameter int N_DIGITS = N_DIGITS_DEF,
  parameter int W_BIN    = W_BIN_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [W_BIN-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  over,
  output logic [4*N_DIGITS-1:0] bcd
);

  localparam int               CNT_W   = $clog2(W_BIN + 1);
  localparam logic [W_BIN-1:0] MAX_VAL = W_BIN'(10 ** N_DIGITS - 1);

  conv_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [W_BIN-1:0]      bin_q, bin_d;
  logic [4*N_DIGITS-1:0] scr_q, scr_d;
  logic                  over_q, over_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [4*N_DIGITS-1:0]       adj;
  logic [4*N_DIGITS+W_BIN-1:0] shifted;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    over_d  = over_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      adj[4*i +: 4] = add3(scr_q[4*i +: 4]);
    end
    shifted = {adj, bin_q} << 1;
    case (state_q)
      IDLE: begin
        if (load) begin
          bin_d   = bin_in;
          scr_d   = '0;
          over_d  = (bin_in > MAX_VAL);
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        scr_d = shifted[4*N_DIGITS+W_BIN-1 -: 4*N_DIGITS];
        bin_d = shifted[W_BIN-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(W_BIN - 1)) begin
          state_d = COMMIT;
          done_d  = 1'b1;
        end
      end
      COMMIT: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // done is high for exactly the COMMIT cycle so the consumer latches on the COMMIT edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      scr_q   <= '0;
      over_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      over_q  <= over_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign over = over_q;
  assign bcd  = scr_q;

endmodule

// File: rtl/bin_to_sseg_scan.sv
// rtl/bin_to_sseg_scan.sv - binary to multiplexed BCD digit scanner with leading-zero blanking
module bin_to_sseg_scan
  import bin_to_sseg_scan_pkg::*;
#(
  parameter int N_DIGITS    = N_DIGITS_DEF,
  parameter int W_BIN       = W_BIN_DEF,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [W_BIN-1:0]    bin_in,
  input  logic                load,
  input  logic                blank_lz,
  output logic                busy,
  output logic                ovf,
  output logic [3:0]          bcd_out,
  output logic [N_DIGITS-1:0] an
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic                  conv_busy, conv_done, conv_over;
  logic [4*N_DIGITS-1:0] conv_bcd;

  bin2bcd_seq #(
    .N_DIGITS (N_DIGITS),
    .W_BIN    (W_BIN)
  ) u_conv (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .bin_in (bin_in),
    .busy   (conv_busy),
    .done   (conv_done),
    .over   (conv_over),
    .bcd    (conv_bcd)
  );

  logic [4*N_DIGITS-1:0] disp_q, disp_d;
  logic                  ovf_q, ovf_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [3:0]            bcd_q, bcd_d;
  logic [N_DIGITS-1:0]   an_q, an_d;

  logic             wrap;
  logic [IDX_W-1:0] nidx;
  logic             lz_run;
  logic             lz_sel;

  always_comb begin
    disp_d = disp_q;
    ovf_d  = ovf_q;
    idx_d  = idx_q;
    bcd_d  = bcd_q;
    an_d   = an_q;
    if (conv_done) begin
      disp_d = conv_over ? {N_DIGITS{BCD_ERR}} : conv_bcd;
      ovf_d  = conv_over;
    end
    wrap  = (div_q == DIV_W'(REFRESH_DIV - 1));
    div_d = wrap ? '0 : div_q + DIV_W'(1);
    nidx  = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    // Walk from the MSD down: a digit is a leading zero if it and everything above it is zero.
    lz_run = 1'b1;
    lz_sel = 1'b0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      lz_run = lz_run && (disp_q[4*i +: 4] == 4'h0);
      if (IDX_W'(i) == nidx) begin
        lz_sel = lz_run && (i != 0);
      end
    end
    if (wrap) begin
      idx_d = nidx;
      bcd_d = disp_q[4*nidx +: 4];
      an_d  = (blank_lz && !ovf_q && lz_sel) ? '1 : ~(N_DIGITS'(1) << nidx);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q <= '0;
      ovf_q  <= 1'b0;
      div_q  <= '0;
      idx_q  <= IDX_W'(N_DIGITS - 1);
      bcd_q  <= 4'h0;
      an_q   <= '1;
    end else begin
      disp_q <= disp_d;
      ovf_q  <= ovf_d;
      div_q  <= div_d;
      idx_q  <= idx_d;
      bcd_q  <= bcd_d;
      an_q   <= an_d;
    end
  end

  assign busy    = conv_busy;
  assign ovf     = ovf_q;
  assign bcd_out = bcd_q;
  assign an      = an_q;

endmodule

// File: tb/tb_bin_to_sseg_scan.sv
// tb/tb_bin_to_sseg_scan.sv - self-checking bench with a decimal-arithmetic display model
module tb_bin_to_sseg_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] bin_in = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic        busy;
  logic        ovf;
  logic [3:0]  bcd_out;
  logic [3:0]  an;

  int n_tests = 0;
  int n_fail  = 0;

  bin_to_sseg_scan #(
    .N_DIGITS    (4),
    .W_BIN       (14),
    .REFRESH_DIV (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bin_in   (bin_in),
    .load     (load),
    .blank_lz (blank_lz),
    .busy     (busy),
    .ovf      (ovf),
    .bcd_out  (bcd_out),
    .an       (an)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: displayed value kept as an integer, digits extracted with /10 and %10.
  int       m_k, m_busy_cnt, m_pend_val, m_disp_val;
  bit       m_pend_over, m_disp_ovf, m_ok = 1'b0;
  logic [3:0] m_bcd, m_an;

  function automatic int pow10(input int d);
    int r = 1;
    for (int i = 0; i < d; i++) r = r * 10;
    return r;
  endfunction

  always @(posedge clk) begin
    int   d;
    bit   blank;
    logic [3:0] one_hot;
    if (rst) begin
      m_k = 0; m_busy_cnt = 0; m_disp_val = 0; m_disp_ovf = 1'b0;
      m_bcd = 4'h0; m_an = 4'hF; m_ok = 1'b1;
    end else if (m_ok) begin
      m_k++;
      if (m_k % 4 == 0) begin
        d       = (m_k / 4 - 1) % 4;
        blank   = blank_lz && !m_disp_ovf && d != 0 && m_disp_val < pow10(d);
        one_hot = 4'b0001 << d;
        m_bcd   = m_disp_ovf ? 4'hE : 4'((m_disp_val / pow10(d)) % 10);
        m_an    = blank ? 4'hF : ~one_hot;
      end
      if (m_busy_cnt > 0) begin
        m_busy_cnt--;
        if (m_busy_cnt == 0) begin
          m_disp_val = m_pend_val;
          m_disp_ovf = m_pend_over;
        end
      end else if (load) begin
        m_busy_cnt  = 15;
        m_pend_val  = int'(bin_in);
        m_pend_over = int'(bin_in) > 9999;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("model_busy", int'(busy), int'(m_busy_cnt > 0));
      check("model_ovf", int'(ovf), int'(m_disp_ovf));
      check("model_an", int'(an), int'(m_an));
      check("model_bcd", int'(bcd_out), int'(m_bcd));
    end
  end

  task automatic do_load(input logic [13:0] v, input logic blz);
    @(negedge clk);
    bin_in   = v;
    blank_lz = blz;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  task automatic wait_idle();
    int c = 0;
    while (busy && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("wait_idle", int'(busy), 0);
    repeat (16) @(negedge clk);
  endtask

  task automatic wait_an(input logic [3:0] pat);
    int c = 0;
    while (an !== pat && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("wait_an", int'(an), int'(pat));
  endtask

  task automatic check_digits(input string name, input int d3, input int d2, input int d1, input int d0);
    int exp[4];
    logic [3:0] pat;
    exp = '{d0, d1, d2, d3};
    for (int d = 0; d < 4; d++) begin
      pat = ~(4'b0001 << d);
      wait_an(pat);
      check(name, int'(bcd_out), exp[d]);
    end
  endtask

  task automatic check_blanked(input string name, input int d0);
    int n_on = 0;
    int n_off = 0;
    wait_an(4'b1110);
    check(name, int'(bcd_out), d0);
    for (int i = 0; i < 16; i++) begin
      if (an == 4'b1110) n_on++;
      if (an == 4'b1111) n_off++;
      @(negedge clk);
    end
    check({name, "_on"}, n_on, 4);
    check({name, "_off"}, n_off, 12);
  endtask

  initial begin
    int c;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_an", int'(an), 15);
    check("rst_bcd", int'(bcd_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ovf", int'(ovf), 0);
    repeat (2) @(negedge clk);
    check("pre_wrap_an", int'(an), 15);
    repeat (20) @(negedge clk);

    do_load(14'd1234, 1'b0);
    c = 0;
    while (busy && c < 100) begin
      c++;
      @(negedge clk);
    end
    check("busy_cycles", c, 15);
    wait_idle();
    check_digits("d1234", 1, 2, 3, 4);

    do_load(14'd7, 1'b1);
    wait_idle();
    check_blanked("blank7", 7);

    do_load(14'd0, 1'b1);
    wait_idle();
    check_blanked("blank0", 0);

    do_load(14'd12000, 1'b1);
    wait_idle();
    check("ovf_12000", int'(ovf), 1);
    check_digits("ovf_digits", 14, 14, 14, 14);

    do_load(14'd9999, 1'b0);
    repeat (2) @(negedge clk);
    do_load(14'd5, 1'b0);
    wait_idle();
    check("ovf_9999", int'(ovf), 0);
    check_digits("d9999", 9, 9, 9, 9);

    do_load(14'd4321, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", int'(busy), 0);
    repeat (20) @(negedge clk);
    check("rst_mid_busy_late", int'(busy), 0);
    check_digits("rst_mid_disp", 0, 0, 0, 0);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bin_to_sseg_scan.md
Name: bin_to_sseg_scan

Overview:
- Upstream feeder for the 4-bit-BCD-to-seven-segment decoder.
- Accepts a binary value on a load strobe and converts it to BCD sequentially using shift-and-add-3 (double dabble).
- Time-multiplexes the digits onto a single 4-bit BCD bus that drives the decoder, with matching active-low digit (anode) enables.
- Supports leading-zero blanking and shows an "EEEE" overflow pattern.

Parameters:
- N_DIGITS, 4: number of multiplexed digits.
- W_BIN, 14: binary input width; the value must satisfy 10^N_DIGITS - 1 < 2^W_BIN.
- REFRESH_DIV, 50000: clock cycles each digit stays active.

Ports:
- clk, input, 1: system clock; all logic is rising-edge.
- rst, input, 1: synchronous, active-high reset.
- bin_in, input, W_BIN: binary value to display.
- load, input, 1: one-cycle strobe that captures bin_in.
- blank_lz, input, 1: when 1, leading-zero digits are blanked.
- busy, output, 1: conversion in progress.
- ovf, output, 1: the last loaded value exceeded 10^N_DIGITS - 1.
- bcd_out, output, 4: BCD nibble for the currently active digit; goes to the decoder.
- an, output, N_DIGITS: digit enables, active-low, one-hot-zero.

Behaviour:
- Reset, synchronous: every register clears in the same cycle, including an in-progress conversion.
  - busy=0, ovf=0, bcd_out=4'h0, an=all ones.
  - Display register = all zeros; divider = 0; digit index = N_DIGITS-1.
- Converter FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: load=1 latches bin_in, clears the BCD scratch register, and records over = (bin_in > 10^N_DIGITS - 1). Then goes to SHIFT with busy=1.
  - SHIFT: runs exactly W_BIN cycles. Each cycle, every scratch nibble >= 5 gets +3, then {scratch, bin} shifts left by 1 (MSB first).
  - COMMIT: one cycle.
    - Display register <= scratch, or every nibble = 4'hE if over.
    - ovf <= over; busy <= 0; return to IDLE.
  - Latency: load sampled at edge t gives the display register and ovf updated at edge t+W_BIN+1. busy is high for W_BIN+1 cycles.
  - load while busy is ignored; no queuing.
  - An overflowing value takes the same latency as a valid one.
- Scan:
  - Divider counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, idx <= (idx+1) mod N_DIGITS. On the same edge, bcd_out <= display[next idx] and an <= ~(1<<next idx).
  - bcd_out and an are registered and change only on a divider wrap. A display-register update becomes visible at the next wrap.
  - First wrap after reset selects digit 0, the least-significant digit (LSD).
- Blanking:
  - A digit is blanked when blank_lz=1, ovf=0, its nibble is 0, and all more-significant nibbles are 0.
  - The LSD is never blanked.
  - For a blanked digit, an = all ones and bcd_out still carries 4'h0.
- Simultaneous events:
  - COMMIT coinciding with a wrap: the wrap samples the old display register.
  - rst has priority over load and over a wrap.

Decomposition:
- Shared package holds:
  - BCD_ERR = 4'hE.
  - Digit-count and width localparams.
  - The FSM state enum {IDLE, SHIFT, COMMIT}.
- One natural sub-module: bin2bcd_seq (the converter FSM plus scratch register, with handshake load/busy/done). The scan/blank logic stays in the top.

Test Plan:
Use REFRESH_DIV=4 in simulation.
- Reset, then idle: an=4'b1111 until the first wrap (cycle 4). Then an cycles 1110, 1101, 1011, 0111 every 4 cycles, with bcd_out=0 throughout.
- load with bin_in=1234, blank_lz=0:
  - busy is high for 15 cycles.
  - After commit, the scan shows bcd_out 4,3,2,1 with an 1110, 1101, 1011, 0111 respectively.
- load 7 with blank_lz=1: digit 0 is active (an=1110, bcd_out=7); digits 1-3 show an=1111.
- load 0 with blank_lz=1: only digit 0 is enabled, bcd_out=0.
- load 12000: ovf=1, all digits show 4'hE, and no blanking occurs even with blank_lz=1.
- Busy/reset interactions:
  - load 9999, then load 5 three cycles later: the second load is ignored and the display is 9,9,9,9.
  - Asserting rst mid-SHIFT: busy=0 next cycle and the display stays all zeros.
